// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - in-order write-back FIFO feeding the register file write port
// Optional pending-write forwarding to the read ports is built when WBQ_FORWARD_EN is defined.
module regfile_writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int REG_W  = 5,
   parameter int DATA_W = 32
) (
   input  logic                     clock,
   input  logic                     ctrl_reset,
   input  logic                     a_valid,
   input  logic [REG_W-1:0]         a_reg,
   input  logic [DATA_W-1:0]        a_data,
   output logic                     a_ready,
   input  logic                     b_valid,
   input  logic [REG_W-1:0]         b_reg,
   input  logic [DATA_W-1:0]        b_data,
   output logic                     b_ready,
   output logic                     ctrl_writeEnable,
   output logic [REG_W-1:0]         ctrl_writeReg,
   output logic [DATA_W-1:0]        data_writeReg,
   input  logic [REG_W-1:0]         ctrl_readRegA,
   input  logic [REG_W-1:0]         ctrl_readRegB,
   output logic                     fwd_hitA,
   output logic [DATA_W-1:0]        fwd_dataA,
   output logic                     fwd_hitB,
   output logic [DATA_W-1:0]        fwd_dataB,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_M2 = CNT_W'(DEPTH - 2);

   logic [REG_W-1:0]  reg_mem_q  [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  occ_q, occ_d;
   logic [PTR_W-1:0]  b_slot;
   logic              a_push, b_push, pop;

   always_comb begin
      // Readiness looks only at the registered count; the same-cycle pop is not credited.
      a_ready = (occ_q < DEPTH_C);
      b_ready = a_valid ? (occ_q <= DEPTH_M2) : (occ_q < DEPTH_C);
      a_push  = a_valid & a_ready & (a_reg != '0);
      b_push  = b_valid & b_ready & (b_reg != '0);
      pop     = (occ_q != '0);
      b_slot  = a_push ? tail_q + PTR_W'(1) : tail_q;
      tail_d  = tail_q + PTR_W'(a_push) + PTR_W'(b_push);
      head_d  = pop ? head_q + PTR_W'(1) : head_q;
      occ_d   = occ_q + CNT_W'(a_push) + CNT_W'(b_push) - CNT_W'(pop);
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   // Storage needs no reset: only slots inside [head, head+occupancy) are ever observed.
   always_ff @(posedge clock) begin
      if (a_push) begin
         reg_mem_q[tail_q]  <= a_reg;
         data_mem_q[tail_q] <= a_data;
      end
      if (b_push) begin
         reg_mem_q[b_slot]  <= b_reg;
         data_mem_q[b_slot] <= b_data;
      end
   end

   assign occupancy        = occ_q;
   assign ctrl_writeEnable = pop;
   assign ctrl_writeReg    = pop ? reg_mem_q[head_q]  : '0;
   assign data_writeReg    = pop ? data_mem_q[head_q] : '0;

`ifdef WBQ_FORWARD_EN
   // Walk oldest to newest so the entry closest to the tail wins.
   function automatic logic [DATA_W:0] fwd_lookup(input logic [REG_W-1:0] rd);
      logic [DATA_W:0]  res;
      logic [PTR_W-1:0] idx;
      res = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if ((CNT_W'(i) < occ_q) && (rd != '0) && (reg_mem_q[idx] == rd))
            res = {1'b1, data_mem_q[idx]};
      end
      return res;
   endfunction

   assign {fwd_hitA, fwd_dataA} = fwd_lookup(ctrl_readRegA);
   assign {fwd_hitB, fwd_dataB} = fwd_lookup(ctrl_readRegB);
`else
   logic unused_read_idx;
   assign unused_read_idx = ^{ctrl_readRegA, ctrl_readRegB};
   assign fwd_hitA  = 1'b0;
   assign fwd_dataA = '0;
   assign fwd_hitB  = 1'b0;
   assign fwd_dataB = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - scoreboard bench for regfile_writeback_queue
// Forwarding expectations follow WBQ_FORWARD_EN, matching the build of the design.
module tb_regfile_writeback_queue;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   logic        clock;
   logic        ctrl_reset;
   logic        a_valid, b_valid;
   logic [4:0]  a_reg, b_reg;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [4:0]  ctrl_readRegA, ctrl_readRegB;
   logic        fwd_hitA, fwd_hitB;
   logic [31:0] fwd_dataA, fwd_dataB;
   logic [2:0]  occupancy;

   ent_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   regfile_writeback_queue #(.DEPTH(DEPTH), .REG_W(5), .DATA_W(32)) dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .a_valid          (a_valid),
      .a_reg            (a_reg),
      .a_data           (a_data),
      .a_ready          (a_ready),
      .b_valid          (b_valid),
      .b_reg            (b_reg),
      .b_data           (b_data),
      .b_ready          (b_ready),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .ctrl_readRegA    (ctrl_readRegA),
      .ctrl_readRegB    (ctrl_readRegB),
      .fwd_hitA         (fwd_hitA),
      .fwd_dataA        (fwd_dataA),
      .fwd_hitB         (fwd_hitB),
      .fwd_dataB        (fwd_dataB),
      .occupancy        (occupancy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fwd_model(input logic [4:0] rd, output logic hit, output logic [31:0] data);
      hit  = 1'b0;
      data = '0;
`ifdef WBQ_FORWARD_EN
      foreach (sb[k]) begin
         if (rd != 5'd0 && sb[k].r == rd) begin
            hit  = 1'b1;
            data = sb[k].d;
         end
      end
`endif
   endtask

   task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd,
                       input logic [4:0] ra, input logic [4:0] rb);
      logic        exp_we, exp_ar, exp_br, hit_a, hit_b;
      logic [4:0]  exp_r;
      logic [31:0] exp_d, fd_a, fd_b;
      ent_t        e;
      a_valid = av; a_reg = ar; a_data = ad;
      b_valid = bv; b_reg = br; b_data = bd;
      ctrl_readRegA = ra; ctrl_readRegB = rb;
      #1;
      exp_we = (sb.size() != 0);
      exp_r  = exp_we ? sb[0].r : 5'd0;
      exp_d  = exp_we ? sb[0].d : 32'd0;
      exp_ar = (sb.size() < DEPTH);
      exp_br = av ? (sb.size() <= DEPTH - 2) : (sb.size() < DEPTH);
      fwd_model(ra, hit_a, fd_a);
      fwd_model(rb, hit_b, fd_b);
      check("occupancy", 32'(occupancy), 32'(sb.size()));
      check("write_enable", 32'(ctrl_writeEnable), 32'(exp_we));
      check("write_reg", 32'(ctrl_writeReg), 32'(exp_r));
      check("write_data", data_writeReg, exp_d);
      check("a_ready", 32'(a_ready), 32'(exp_ar));
      check("b_ready", 32'(b_ready), 32'(exp_br));
      check("fwd_hitA", 32'(fwd_hitA), 32'(hit_a));
      check("fwd_dataA", fwd_dataA, fd_a);
      check("fwd_hitB", 32'(fwd_hitB), 32'(hit_b));
      check("fwd_dataB", fwd_dataB, fd_b);
      if (sb.size() != 0) void'(sb.pop_front());
      if (av && exp_ar && ar != 5'd0) begin e.r = ar; e.d = ad; sb.push_back(e); end
      if (bv && exp_br && br != 5'd0) begin e.r = br; e.d = bd; sb.push_back(e); end
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
   endtask

   initial begin
      ctrl_reset = 1'b1;
      a_valid = 1'b0; a_reg = '0; a_data = '0;
      b_valid = 1'b0; b_reg = '0; b_data = '0;
      ctrl_readRegA = '0; ctrl_readRegB = '0;
      #1;
      check("reset_occupancy", 32'(occupancy), 32'd0);
      check("reset_write_enable", 32'(ctrl_writeEnable), 32'd0);
      check("reset_write_reg", 32'(ctrl_writeReg), 32'd0);
      check("reset_write_data", data_writeReg, 32'd0);
      check("reset_fwd_hitA", 32'(fwd_hitA), 32'd0);
      check("reset_fwd_dataB", fwd_dataB, 32'd0);
      @(posedge clock);
      #1 ctrl_reset = 1'b0;

      idle(5'd0, 5'd0);
      idle(5'd0, 5'd0);

      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      idle(5'd5, 5'd0);
      idle(5'd5, 5'd0);

      step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd0, 5'd0);
      idle(5'd3, 5'd0);
      idle(5'd3, 5'd3);
      idle(5'd3, 5'd0);

      step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      idle(5'd0, 5'd0);

      step(1'b1, 5'd7, 32'h0000_0777, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
      idle(5'd7, 5'd7);
      idle(5'd7, 5'd0);

      for (int i = 0; i < 10; i++)
         step(1'b1, 5'(1 + 2 * i), $urandom, 1'b1, 5'(2 + 2 * i), $urandom,
              5'(1 + 2 * i), 5'(2 * i));
      for (int k = 0; k < 8; k++) idle(5'd0, 5'd0);

      step(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'hA, 5'd0, 5'd0);
      step(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC, 5'd0, 5'd0);
      a_valid = 1'b0; b_valid = 1'b0;
      #1;
      check("pre_reset_occupancy", 32'(occupancy), 32'(sb.size()));
      ctrl_reset = 1'b1;
      #1;
      check("async_reset_occupancy", 32'(occupancy), 32'd0);
      check("async_reset_write_enable", 32'(ctrl_writeEnable), 32'd0);
      check("async_reset_write_reg", 32'(ctrl_writeReg), 32'd0);
      sb.delete();
      @(posedge clock);
      #1 ctrl_reset = 1'b0;
      idle(5'd9, 5'd11);

      for (int i = 0; i < 40; i++)
         step(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      for (int k = 0; k < 8; k++) idle(5'd0, 5'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      if (n_fail != 0)
         $error("FAIL summary: %0d of %0d checks failed", n_fail, n_checks);
      else
         $display("PASS");
      $finish;
   end

endmodule
